// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared definitions for the bit-serial CORDIC sequencer and its slices.
// Holds the FSM state type, default geometry and the arctan ROM that the z slice indexes by iter_idx.
package cordic_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ITERS = 16;
  localparam int DEF_IW    = 4;
  localparam int ATAN_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // atan(2^-i) with a full circle mapped to 2^16, so 45 degrees = 0x2000
  function automatic logic [ATAN_W-1:0] atan_rom(input logic [3:0] idx);
    logic [ATAN_W-1:0] v;
    v = '0;
    case (idx)
      4'd0:  v = 16'h2000;
      4'd1:  v = 16'h12E4;
      4'd2:  v = 16'h09FB;
      4'd3:  v = 16'h0511;
      4'd4:  v = 16'h028B;
      4'd5:  v = 16'h0146;
      4'd6:  v = 16'h00A3;
      4'd7:  v = 16'h0051;
      4'd8:  v = 16'h0029;
      4'd9:  v = 16'h0014;
      4'd10: v = 16'h000A;
      4'd11: v = 16'h0005;
      4'd12: v = 16'h0003;
      4'd13: v = 16'h0001;
      4'd14: v = 16'h0001;
      4'd15: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Host/slice-facing control bundle of the CORDIC sequencer.
// master = host and slices (drive start/abort/z_msb); slave = sequencer.
interface cordic_seq_ctrl_if #(parameter int IW = 4);
  logic          start;
  logic          abort;
  logic          z_msb;
  logic          busy;
  logic          done;
  logic          load;
  logic          shift_en;
  logic          first_bit;
  logic          last_bit;
  logic [IW-1:0] iter_idx;
  logic [IW-1:0] bit_idx;
  logic          dir;

  modport master (
    output start, abort, z_msb,
    input  busy, done, load, shift_en, first_bit, last_bit, iter_idx, bit_idx, dir
  );

  modport slave (
    input  start, abort, z_msb,
    output busy, done, load, shift_en, first_bit, last_bit, iter_idx, bit_idx, dir
  );
endinterface

// File: rtl/cordic_seq_ctrl_cnt.sv
// Bit/iteration counter: bit_idx wraps at WIDTH-1, iter_idx saturates at ITERS-1.
// Updates on the edge after i_en; i_clr overrides i_en; o_term flags the final bit of the final iteration.
module cordic_seq_ctrl_cnt #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16,
  parameter int IW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_bit_idx,
  output logic [IW-1:0] o_iter_idx,
  output logic          o_last_bit,
  output logic          o_term
);

  logic [IW-1:0] r_bit_idx;
  logic [IW-1:0] r_iter_idx;
  logic          w_last_bit;
  logic          w_last_iter;

  assign w_last_bit  = (r_bit_idx == IW'(WIDTH - 1));
  assign w_last_iter = (r_iter_idx == IW'(ITERS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx  <= '0;
      r_iter_idx <= '0;
    end else if (i_clr) begin
      r_bit_idx  <= '0;
      r_iter_idx <= '0;
    end else if (i_en) begin
      if (w_last_bit) begin
        r_bit_idx <= '0;
        if (!w_last_iter) r_iter_idx <= r_iter_idx + IW'(1);
      end else begin
        r_bit_idx <= r_bit_idx + IW'(1);
      end
    end
  end

  assign o_bit_idx  = r_bit_idx;
  assign o_iter_idx = r_iter_idx;
  assign o_last_bit = w_last_bit;
  assign o_term     = w_last_bit & w_last_iter;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the bit-serial CORDIC slices: start/done handshake plus load/shift/bit/iteration/direction strobes.
// done lands 2+ITERS*WIDTH cycles after start is sampled; start while busy is dropped, abort returns to IDLE next edge.
module cordic_seq_ctrl
  import cordic_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITERS = DEF_ITERS,
  parameter int IW    = DEF_IW
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  cordic_seq_ctrl_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_dir;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_last_bit;
  logic          w_term;
  logic [IW-1:0] w_bit_idx;
  logic [IW-1:0] w_iter_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b1;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_cnt_en  = 1'b1;
        w_cnt_clr = 1'b0;
        if (w_term) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_en    = 1'b0;
      w_cnt_clr   = 1'b1;
    end
  end

  cordic_seq_ctrl_cnt #(
    .WIDTH (WIDTH),
    .ITERS (ITERS),
    .IW    (IW)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .o_bit_idx  (w_bit_idx),
    .o_iter_idx (w_iter_idx),
    .o_last_bit (w_last_bit),
    .o_term     (w_term)
  );

  // z_msb is only trustworthy before the first shift and right after each iteration's MSB lands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir <= 1'b0;
    end else if (bus.abort || r_state == ST_DONE) begin
      r_dir <= 1'b0;
    end else if (r_state == ST_LOAD || (r_state == ST_RUN && w_last_bit)) begin
      r_dir <= bus.z_msb;
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.load      = (r_state == ST_LOAD);
  assign bus.shift_en  = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.first_bit = (r_state == ST_RUN) && (w_bit_idx == '0);
  assign bus.last_bit  = (r_state == ST_RUN) && w_last_bit;
  assign bus.iter_idx  = w_iter_idx;
  assign bus.bit_idx   = w_bit_idx;
  assign bus.dir       = r_dir;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: vector table of whole operations plus hand sequences, done pulses checked via queue.
module tb_cordic_seq_ctrl;
  import cordic_seq_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int I  = 16;
  localparam int N  = W * I;
  localparam int W2 = 8;
  localparam int I2 = 4;
  localparam int N2 = W2 * I2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   q[$];
  int   q2[$];
  int   mon_exp;
  int   mon_exp2;

  cordic_seq_ctrl_if #(.IW(4)) bus ();
  cordic_seq_ctrl_if #(.IW(3)) bus2 ();

  cordic_seq_ctrl #(.WIDTH(W), .ITERS(I), .IW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  cordic_seq_ctrl #(.WIDTH(W2), .ITERS(I2), .IW(3)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // every done pulse must match the cycle predicted when its start was issued
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        mon_exp = q.pop_front();
        if (mon_exp != cyc) begin
          bad++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, mon_exp);
        end
      end
    end
    if (rst_n && bus2.done) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL done2_unexpected: got done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        mon_exp2 = q2.pop_front();
        if (mon_exp2 != cyc) begin
          bad++;
          $display("FAIL done2_cycle: got %0d required %0d", cyc, mon_exp2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string t);
    chk({t, ".busy"},      32'(bus.busy), 0);
    chk({t, ".done"},      32'(bus.done), 0);
    chk({t, ".load"},      32'(bus.load), 0);
    chk({t, ".shift_en"},  32'(bus.shift_en), 0);
    chk({t, ".first_bit"}, 32'(bus.first_bit), 0);
    chk({t, ".last_bit"},  32'(bus.last_bit), 0);
    chk({t, ".dir"},       32'(bus.dir), 0);
    chk({t, ".iter_idx"},  32'(bus.iter_idx), 0);
    chk({t, ".bit_idx"},   32'(bus.bit_idx), 0);
  endtask

  function automatic logic fdir(input int mode, input int it);
    if (mode == 1) return 1'(it % 2);
    if (mode == 2) return 1'b1;
    return 1'b0;
  endfunction

  // mode: 0 z_msb held 0, 1 alternating per iteration, 2 held 1 (modes 1/2 scramble z_msb between captures)
  typedef struct {
    int mode;
    int ab_it;
    int ab_bt;
    bit xstart;
    bit exp_done;
  } vec_t;

  // entered in an IDLE cycle; leaves in the IDLE cycle after done, or the cycle after abort
  task automatic run_op(input vec_t v);
    int  it;
    int  bt;
    bit  cap;
    int  nxt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (v.exp_done) q.push_back(cyc + N + 1);
    for (int c = 1; c <= N + 3; c++) begin
      it = (c >= 2) ? (c - 2) / W : 0;
      bt = (c >= 2) ? (c - 2) % W : 0;
      if (c == 1) begin
        chk("load", 32'(bus.load), 1);
        chk("load.busy", 32'(bus.busy), 1);
        chk("load.shift_en", 32'(bus.shift_en), 0);
        chk("load.bit_idx", 32'(bus.bit_idx), 0);
        chk("load.iter_idx", 32'(bus.iter_idx), 0);
      end else if (c <= N + 1) begin
        chk("run.shift_en", 32'(bus.shift_en), 1);
        chk("run.load", 32'(bus.load), 0);
        chk("run.done", 32'(bus.done), 0);
        chk("run.bit_idx", 32'(bus.bit_idx), 32'(bt));
        chk("run.iter_idx", 32'(bus.iter_idx), 32'(it));
        chk("run.first_bit", 32'(bus.first_bit), 32'(bt == 0));
        chk("run.last_bit", 32'(bus.last_bit), 32'(bt == W - 1));
        chk("run.dir", 32'(bus.dir), 32'(fdir(v.mode, it)));
      end else if (c == N + 2) begin
        chk("done", 32'(bus.done), 1);
        chk("done.busy", 32'(bus.busy), 1);
        chk("done.shift_en", 32'(bus.shift_en), 0);
        chk("done.iter_idx", 32'(bus.iter_idx), 32'(I - 1));
      end else begin
        chk("post.busy", 32'(bus.busy), 0);
        chk("post.done", 32'(bus.done), 0);
      end
      bus.start = v.xstart && (c == 5 || c == 100 || c == N + 1 || c == N + 2);
      cap = (c == 1) || (c >= 2 && c <= N + 1 && bt == W - 1);
      nxt = (c == 1) ? 0 : it + 1;
      if (v.mode == 0)  bus.z_msb = 1'b0;
      else if (cap)     bus.z_msb = fdir(v.mode, nxt);
      else              bus.z_msb = 1'($urandom % 2);
      if (c >= 2 && c <= N + 1 && it == v.ab_it && bt == v.ab_bt) begin
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.z_msb = 1'b0;
        chk_idle("abort");
        return;
      end
      if (c < N + 3) step();
    end
    bus.z_msb = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{mode: 0, ab_it: -1, ab_bt: -1, xstart: 1'b0, exp_done: 1'b1};
    vecs[1] = '{mode: 1, ab_it: -1, ab_bt: -1, xstart: 1'b0, exp_done: 1'b1};
    vecs[2] = '{mode: 2, ab_it: -1, ab_bt: -1, xstart: 1'b0, exp_done: 1'b1};
    vecs[3] = '{mode: 0, ab_it: -1, ab_bt: -1, xstart: 1'b1, exp_done: 1'b1};
    vecs[4] = '{mode: 1, ab_it: 7,  ab_bt: 3,  xstart: 1'b0, exp_done: 1'b0};
    vecs[5] = '{mode: 0, ab_it: -1, ab_bt: -1, xstart: 1'b0, exp_done: 1'b1};
    vecs[6] = '{mode: 1, ab_it: 15, ab_bt: 15, xstart: 1'b0, exp_done: 1'b0};
    vecs[7] = '{mode: 2, ab_it: 0,  ab_bt: 0,  xstart: 1'b1, exp_done: 1'b0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.z_msb = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.z_msb = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset2.busy", 32'(bus2.busy), 0);
    step();
    rst_n = 1'b1;
    step();
    chk_idle("released");

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort.busy", 32'(bus.busy), 0);
    chk("start_abort.load", 32'(bus.load), 0);
    step();
    chk("start_abort.busy2", 32'(bus.busy), 0);

    for (int k = 0; k < 8; k++) run_op(vecs[k]);

    // reset mid-RUN during iteration 10 with dir=1
    bus.z_msb = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 2 + 10 * W + 5; c++) step();
    chk("pre_reset.dir", 32'(bus.dir), 1);
    chk("pre_reset.iter_idx", 32'(bus.iter_idx), 10);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    bus.z_msb = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle("after_reset");
    run_op(vecs[1]);

    // narrow geometry: WIDTH=8, ITERS=4
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    q2.push_back(cyc + N2 + 1);
    for (int c = 1; c <= N2 + 3; c++) begin
      if (c == 1) begin
        chk("p2.load", 32'(bus2.load), 1);
      end else if (c <= N2 + 1) begin
        chk("p2.shift_en", 32'(bus2.shift_en), 1);
        chk("p2.bit_idx", 32'(bus2.bit_idx), 32'((c - 2) % W2));
        chk("p2.iter_idx", 32'(bus2.iter_idx), 32'((c - 2) / W2));
        chk("p2.last_bit", 32'(bus2.last_bit), 32'((c - 2) % W2 == W2 - 1));
      end else if (c == N2 + 2) begin
        chk("p2.done", 32'(bus2.done), 1);
        chk("p2.iter_idx_hold", 32'(bus2.iter_idx), 3);
      end else begin
        chk("p2.busy", 32'(bus2.busy), 0);
      end
      if (c < N2 + 3) step();
    end

    step();
    step();
    chk("q_empty", 32'(q.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencer for the bit-serial CORDIC datapath: it owns the start/done handshake and drives the control strobes for the x, y and z bit-serial slices. Per operation it does the following:
- produces the operand load;
- produces the per-bit shift enable;
- produces the arctan ROM index;
- produces the carry-init strobe;
- produces the per-iteration rotation direction.

It sits between the host logic that issues angle requests and the three slice datapaths, replacing their free-running local counters.

## Interface
Parameters:
- WIDTH, 16, serial word length (bits per iteration); power of two, ≥4
- ITERS, 16, CORDIC iterations per operation; ≤ 2^IW
- IW, 4, width of iter_idx and bit_idx, = clog2(max(WIDTH, ITERS))

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE without done
- z_msb  in  1  current sign bit of z register (1 = negative)
- busy  out  1  high in LOAD, RUN, DONE
- done  out  1  one-cycle pulse, result registers valid
- load  out  1  parallel load of x0/y0/z0 into slices
- shift_en  out  1  slice registers shift one bit
- first_bit  out  1  LSB cycle of an iteration (slices set carry-in = subtract flag)
- last_bit  out  1  MSB cycle of an iteration
- iter_idx  out  IW  current iteration = arctan ROM address = cross-term shift amount
- bit_idx  out  IW  current bit position within the word
- dir  out  1  rotation direction for the current iteration: 0 = z≥0 (z subtracts atan, x/y rotate positive), 1 = z<0

## Operation
- States: IDLE, LOAD, RUN, DONE; 2-bit encoding, registered.
- IDLE:
  - all strobes 0.
  - start=1 → LOAD.
- LOAD:
  - load=1 for exactly one cycle;
  - iter_idx and bit_idx cleared to 0;
  - → RUN.
- dir is captured from z_msb in the cycle following load, i.e. the first RUN cycle, before any shift has altered z. Method: dir is registered from z_msb on the clock edge that leaves LOAD.
- RUN:
  - shift_en=1 every cycle.
  - bit_idx counts 0..WIDTH-1 and wraps to 0.
  - first_bit = (bit_idx==0); last_bit = (bit_idx==WIDTH-1).
  - On a last_bit cycle: iter_idx increments, and dir is re-registered from z_msb, since the final bit of the new z has been shifted into the MSB on that same edge. dir is therefore constant across all WIDTH cycles of an iteration.
  - On last_bit with iter_idx==ITERS-1: → DONE. iter_idx does not increment past ITERS-1.
- DONE:
  - done=1 for one cycle; shift_en=0;
  - → IDLE.
- abort=1 in any non-IDLE state:
  - → IDLE next edge; done never asserts;
  - counters cleared;
  - abort has priority over all transitions.
- start while busy: ignored, not queued.
- start and abort together in IDLE: abort wins, stay IDLE.
- Counters are unsigned modulo 2^IW. bit_idx wrap uses the explicit compare to WIDTH-1, not overflow.

## Timing
- Reset (rst_n=0, async):
  - state=IDLE;
  - busy, done, load, shift_en, first_bit, last_bit, dir = 0;
  - iter_idx = bit_idx = 0.
- Deassertion is sampled synchronously; the first transition is possible on the first edge after release.
- All outputs are registered or decoded purely from registered state. No combinational path from inputs to outputs.
- Latency, with start sampled at edge 0:
  - load high in cycle 1;
  - shift_en high in cycles 2 .. 1+ITERS·WIDTH;
  - done high in cycle 2+ITERS·WIDTH, which is 258 for the defaults.
- busy falls in the cycle after done. The earliest next accepted start is sampled on the edge ending the done cycle +1, so back-to-back throughput is one op per ITERS·WIDTH+3 cycles.
- rst_n asserted mid-RUN: immediate return to reset values; slices are reloaded on the next start.

## Structure
- Shared package cordic_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - default WIDTH/ITERS/IW localparams;
  - the arctan ROM contents, which the z slice indexes by iter_idx.
- Single module, no sub-module required. The optional natural split is cordic_bit_counter (bit_idx/iter_idx with wrap and terminal flag) if reused by the slices.

## Test plan
- Reset then single op, z_msb held 0 → load in cycle 1; 256 shift_en cycles; first_bit at bit_idx 0 of each of 16 iterations; done exactly at cycle 258; dir=0 throughout.
- z_msb toggled at every last_bit edge → dir alternates 0,1,0,… per iteration and never changes mid-iteration.
- start pulsed at cycles 5, 100, 257 during an op → ignored; exactly one done. A start in the cycle after done is accepted.
- abort at iter_idx=7, bit_idx=3 → IDLE next cycle; busy=0; counters=0; no done pulse. A subsequent start gives a full 258-cycle op.
- rst_n low mid-RUN (iter 10) → all outputs 0 asynchronously, before the next edge. Recovery op completes normally.
- Parameter run WIDTH=8, ITERS=4, IW=3 → done at cycle 34; bit_idx wraps at 7; iter_idx stops at 3.
